// File: rtl/renkon_seq.sv
`timescale 1ns/1ps
// Layer sequencer for the renkon conv engine: walks one conv layer output-stationary
// over core groups, drives memory addresses and PE control, then serialises results.
module renkon_seq #(
  parameter int unsigned CORE     = 8,
  parameter int unsigned IMGSIZE  = 12,
  parameter int unsigned NETSIZE  = 11,
  parameter int unsigned LWIDTH   = 10,
  parameter int unsigned CORE_LAT = 4
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic                      req,
  input  logic                      img_we,
  input  logic [IMGSIZE-1:0]        input_addr,
  input  logic [IMGSIZE-1:0]        output_addr,
  input  logic [$clog2(CORE):0]     net_we,
  input  logic [NETSIZE-1:0]        net_addr,
  input  logic [LWIDTH-1:0]         total_out,
  input  logic [LWIDTH-1:0]         total_in,
  input  logic [LWIDTH-1:0]         img_size,
  input  logic [LWIDTH-1:0]         fil_size,
  output logic                      ack,
  output logic                      mem_img_we,
  output logic [IMGSIZE-1:0]        mem_img_addr,
  output logic [CORE-1:0]           mem_net_we,
  output logic [NETSIZE-1:0]        mem_net_addr,
  output logic                      pix_valid,
  output logic                      first_in,
  output logic                      last_in,
  output logic [CORE-1:0]           core_en,
  output logic [$clog2(CORE)-1:0]   out_sel
);

  localparam int unsigned SELW = $clog2(CORE);
  localparam int unsigned NWEW = $clog2(CORE) + 1;
  localparam int unsigned CNTW = $clog2(CORE) + 1;
  localparam int unsigned LATW = $clog2(CORE_LAT + 1);
  localparam int unsigned GW   = LWIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t               state, state_n;
  logic [IMGSIZE-1:0]   in_base, in_base_n, out_base, out_base_n;
  logic [LWIDTH-1:0]    t_out, t_out_n, t_in, t_in_n, i_sz, i_sz_n, f_sz, f_sz_n;
  logic [LWIDTH-1:0]    og, og_n, y, y_n, x, x_n, ii, ii_n, fy, fy_n, fx, fx_n;
  logic [LATW-1:0]      wcnt, wcnt_n;
  logic [CNTW-1:0]      wc, wc_n;

  logic                 ack_d, img_we_d, pix_valid_d, first_d, last_d;
  logic [IMGSIZE-1:0]   img_addr_d;
  logic [NETSIZE-1:0]   net_addr_d;
  logic [CORE-1:0]      net_we_d, core_en_d;
  logic [SELW-1:0]      out_sel_d;

  // Layer geometry derived from the latched shape
  logic [LWIDTH-1:0]    osz;
  logic [IMGSIZE-1:0]   isz_i, img_sq, osz_i, osz_sq;
  logic [NETSIZE-1:0]   fsz_n, kern, in_k, net_base;
  logic [GW-1:0]        grp_lo, remaining;
  logic                 last_grp, bad_shape;
  logic [CNTW-1:0]      n_act;
  logic [CORE-1:0]      core_mask;
  logic                 fx_last, fy_last, ii_last, x_last, y_last, wc_last, wcnt_last;
  logic [IMGSIZE-1:0]   rd_img_addr, wr_img_addr;
  logic [NETSIZE-1:0]   rd_net_addr;

  always_comb begin
    osz         = i_sz - f_sz + LWIDTH'(1);
    isz_i       = IMGSIZE'(i_sz);
    img_sq      = isz_i * isz_i;
    osz_i       = IMGSIZE'(osz);
    osz_sq      = osz_i * osz_i;
    fsz_n       = NETSIZE'(f_sz);
    kern        = fsz_n * fsz_n;
    in_k        = NETSIZE'(t_in) * kern;
    net_base    = NETSIZE'(og) * in_k;
    grp_lo      = GW'(og) * GW'(CORE);
    remaining   = GW'(t_out) - grp_lo;
    last_grp    = remaining <= GW'(CORE);
    n_act       = last_grp ? CNTW'(remaining) : CNTW'(CORE);
    for (int unsigned c = 0; c < CORE; c++) core_mask[c] = CNTW'(c) < n_act;
    bad_shape   = (t_out == '0) || (t_in == '0) || (f_sz == '0) || (f_sz > i_sz);
    fx_last     = fx == f_sz - LWIDTH'(1);
    fy_last     = fy == f_sz - LWIDTH'(1);
    ii_last     = ii == t_in - LWIDTH'(1);
    x_last      = x == osz - LWIDTH'(1);
    y_last      = y == osz - LWIDTH'(1);
    wc_last     = wc == n_act - CNTW'(1);
    wcnt_last   = wcnt == LATW'(CORE_LAT - 1);
    rd_img_addr = in_base + IMGSIZE'(ii) * img_sq + IMGSIZE'(y + fy) * isz_i
                  + IMGSIZE'(x + fx);
    rd_net_addr = net_base + NETSIZE'(ii) * kern + NETSIZE'(fy) * fsz_n + NETSIZE'(fx);
    wr_img_addr = out_base + IMGSIZE'(grp_lo + GW'(wc)) * osz_sq + IMGSIZE'(y) * osz_i
                  + IMGSIZE'(x);
  end

  // Next state, counters and next registered output values
  always_comb begin
    state_n     = state;
    in_base_n   = in_base;
    out_base_n  = out_base;
    t_out_n     = t_out;
    t_in_n      = t_in;
    i_sz_n      = i_sz;
    f_sz_n      = f_sz;
    og_n        = og;
    y_n         = y;
    x_n         = x;
    ii_n        = ii;
    fy_n        = fy;
    fx_n        = fx;
    wcnt_n      = wcnt;
    wc_n        = wc;
    ack_d       = 1'b0;
    img_we_d    = 1'b0;
    pix_valid_d = 1'b0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    img_addr_d  = '0;
    net_addr_d  = '0;
    net_we_d    = '0;
    core_en_d   = '0;
    out_sel_d   = '0;
    case (state)
      S_IDLE: begin
        img_we_d   = img_we;
        img_addr_d = input_addr;
        net_addr_d = net_addr;
        for (int unsigned c = 0; c < CORE; c++) net_we_d[c] = net_we == NWEW'(c + 1);
        if (req) begin
          state_n    = S_CHECK;
          in_base_n  = input_addr;
          out_base_n = output_addr;
          t_out_n    = total_out;
          t_in_n     = total_in;
          i_sz_n     = img_size;
          f_sz_n     = fil_size;
        end
      end
      S_CHECK: begin
        og_n = '0; y_n = '0; x_n = '0; ii_n = '0; fy_n = '0; fx_n = '0;
        wcnt_n = '0; wc_n = '0;
        state_n = bad_shape ? S_DONE : S_READ;
      end
      S_READ: begin
        pix_valid_d = 1'b1;
        img_addr_d  = rd_img_addr;
        net_addr_d  = rd_net_addr;
        core_en_d   = core_mask;
        first_d     = (ii == '0) && (fy == '0) && (fx == '0);
        last_d      = ii_last && fy_last && fx_last;
        if (!fx_last) fx_n = fx + LWIDTH'(1);
        else begin
          fx_n = '0;
          if (!fy_last) fy_n = fy + LWIDTH'(1);
          else begin
            fy_n = '0;
            if (!ii_last) ii_n = ii + LWIDTH'(1);
            else begin
              ii_n    = '0;
              wcnt_n  = '0;
              state_n = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        core_en_d = core_mask;
        if (wcnt_last) begin
          wc_n    = '0;
          state_n = S_WRITE;
        end else wcnt_n = wcnt + LATW'(1);
      end
      S_WRITE: begin
        img_we_d   = 1'b1;
        img_addr_d = wr_img_addr;
        out_sel_d  = SELW'(wc);
        core_en_d  = core_mask;
        if (!wc_last) wc_n = wc + CNTW'(1);
        else begin
          wc_n    = '0;
          state_n = S_READ;
          if (!x_last) x_n = x + LWIDTH'(1);
          else begin
            x_n = '0;
            if (!y_last) y_n = y + LWIDTH'(1);
            else begin
              y_n = '0;
              if (last_grp) state_n = S_DONE;
              else og_n = og + LWIDTH'(1);
            end
          end
        end
      end
      S_DONE: begin
        ack_d   = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state        <= S_IDLE;
      in_base      <= '0;
      out_base     <= '0;
      t_out        <= '0;
      t_in         <= '0;
      i_sz         <= '0;
      f_sz         <= '0;
      og           <= '0;
      y            <= '0;
      x            <= '0;
      ii           <= '0;
      fy           <= '0;
      fx           <= '0;
      wcnt         <= '0;
      wc           <= '0;
      ack          <= 1'b0;
      mem_img_we   <= 1'b0;
      mem_img_addr <= '0;
      mem_net_we   <= '0;
      mem_net_addr <= '0;
      pix_valid    <= 1'b0;
      first_in     <= 1'b0;
      last_in      <= 1'b0;
      core_en      <= '0;
      out_sel      <= '0;
    end else begin
      state        <= state_n;
      in_base      <= in_base_n;
      out_base     <= out_base_n;
      t_out        <= t_out_n;
      t_in         <= t_in_n;
      i_sz         <= i_sz_n;
      f_sz         <= f_sz_n;
      og           <= og_n;
      y            <= y_n;
      x            <= x_n;
      ii           <= ii_n;
      fy           <= fy_n;
      fx           <= fx_n;
      wcnt         <= wcnt_n;
      wc           <= wc_n;
      ack          <= ack_d;
      mem_img_we   <= img_we_d;
      mem_img_addr <= img_addr_d;
      mem_net_we   <= net_we_d;
      mem_net_addr <= net_addr_d;
      pix_valid    <= pix_valid_d;
      first_in     <= first_d;
      last_in      <= last_d;
      core_en      <= core_en_d;
      out_sel      <= out_sel_d;
    end
  end

endmodule
